sdio_cap_ctrl: RTL and testbench
================================

Name: sdio_cap_ctrl

Overview:
- Capture sequencer for the SD command-line sampler.
- Owns the sampler enable and arms/stops capture sessions; optionally waits for a trigger command index before storing.
- Edge-detects the sampler's finish pulse and queues {cmd, arg} records in a FIFO.
- Drains records as a byte stream with valid/ready handshake toward the SPI bridge, and recovers a hung sampler with a watchdog.

Parameters:
- FIFO_DEPTH, 8, record slots, power of two, 2..64.
- WDOG_CYCLES, 512, consecutive cycles the sampler may stay non-idle before forced recovery.
- RECOVER_CYCLES, 2, cycles smp_en_o is held low during recovery.
- SMP_IDLE, 8'h01, sampler status code meaning idle.

Ports:
- sd_clk  in  1  SD clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- arm_i  in  1  pulse: start new session (flush FIFO, clear counters/flags).
- stop_i  in  1  pulse: end session.
- trig_en_i  in  1  1 = wait for trig_idx_i before storing.
- trig_idx_i  in  6  trigger command index.
- cap_limit_i  in  8  records to store then stop; 0 = unlimited. Sampled at arm.
- smp_en_o  out  1  sampler enable.
- smp_cmd_i  in  8  sampler command index; bits [5:0] used.
- smp_arg_i  in  33  sampler argument; bits [31:0] used.
- smp_finsh_i  in  1  sampler finish flag.
- smp_status_i  in  8  sampler state code.
- byte_o  out  8  output byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  consumer accepts byte.
- busy_o  out  1  state is ARMED, CAPTURING or RECOVER.
- done_o  out  1  state is DONE.
- ovf_o  out  1  sticky: a record was dropped because the FIFO was full.
- rec_cnt_o  out  8  records stored this session; saturates at 255.
- fifo_level_o  out  7  occupied FIFO slots.

Behaviour:
- Reset values:
  - State IDLE.
  - smp_en_o, byte_o, byte_valid_o, busy_o, done_o and ovf_o are all 0.
  - rec_cnt_o and fifo_level_o are 0; FIFO pointers are 0.
- States:
  - IDLE: smp_en_o=0. arm_i -> ARMED if trig_en_i=1, else CAPTURING.
  - ARMED: smp_en_o=1. Each finish event is compared to trig_idx_i. On a match, the record is stored and the state moves to CAPTURING. Non-matching records are discarded.
  - CAPTURING: smp_en_o=1. Every finish event is stored. The state moves to DONE when either:
    - rec_cnt reaches a nonzero cap_limit, or
    - stop_i is asserted.
  - DONE: smp_en_o=0. FIFO drain continues. arm_i restarts the session.
  - RECOVER: smp_en_o=0 for RECOVER_CYCLES, then return to the state the watchdog interrupted (ARMED or CAPTURING).
  - stop_i in ARMED -> DONE.
- Finish event: rising edge of smp_finsh_i (registered previous value), only while smp_en_o=1. Exactly one event per rising edge, regardless of how long the flag stays high.
- Store rules:
  - Push {cmd[5:0], arg[31:0]} on the cycle after the event.
  - If the FIFO is full, drop the record and set ovf_o.
  - A drop never increments rec_cnt.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Byte stream:
  - 5 bytes per record, in order: {2'b00, cmd}, arg[31:24], arg[23:16], arg[15:8], arg[7:0].
  - byte_valid_o rises one cycle after the FIFO becomes non-empty.
  - byte_o is held stable while valid=1 and ready=0.
  - A byte advances on valid&ready. The FIFO pops on acceptance of the last byte.
  - Back-to-back records stream with no idle cycle.
- Watchdog:
  - The counter increments while smp_en_o=1 and smp_status_i is neither SMP_IDLE nor 0. Otherwise it clears.
  - Reaching WDOG_CYCLES -> RECOVER and the counter clears.
  - A partial sampler capture is lost; no record is pushed.
- Simultaneous events:
  - stop_i together with a finish event in CAPTURING: the record is stored, then DONE.
  - arm_i overrides stop_i.
  - arm_i in ARMED, CAPTURING or DONE:
    - flushes the FIFO and clears ovf and rec_cnt;
    - drops byte_valid_o next cycle and restarts the byte index at 0;
    - re-enters ARMED or CAPTURING.
  - arm_i is ignored in RECOVER.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); the FIFO contents are discarded.

Optional Feature:
- SDIO_CAP_TSTAMP_EN defined: a free-running 16-bit sd_clk counter (reset 0, wraps) is latched at each finish event.
  - The timestamp is stored in the record.
  - Records become 7 bytes: the 5 above, then ts[15:8], ts[7:0].
- Undefined: no counter; 5-byte records.

Test Plan:
- Untriggered capture: arm with trig_en=0, cap_limit=3; sampler pulses finish with cmd=17/arg=0x12345678, cmd=18/arg=0xDEADBEEF, then cmd=24. Expect:
  - bytes 11 12 34 56 78, 12 DE AD BE EF, 18 ..;
  - DONE after the 3rd record; smp_en_o=0.
- Trigger filtering: trig_en=1, trig_idx=9; finish events cmd=2, 9, 3. Expect the first stored record to be cmd 9 (then 3), rec_cnt_o=2.
- Backpressure and overflow: FIFO_DEPTH=8, byte_ready_i=0, 10 finish events. Expect:
  - fifo_level_o=8, ovf_o=1, rec_cnt_o=8;
  - byte_o stable throughout.
  - Then with ready=1: exactly 40 bytes drained.
- Watchdog: hold smp_status_i=8'h04 for 512 cycles. Expect smp_en_o low for 2 cycles, then the prior state resumes; no spurious record.
- Stalled finish flag: finish held high for 5 cycles counts as one record. stop_i together with a finish event stores it and then goes DONE.
- Mid-session events:
  - arm_i pulse mid-stream: valid drops next cycle, level=0, ovf=0.
  - rst low mid-stream: all outputs 0 at once.

Source files
------------

// File: rtl/sdio_cap_ctrl.sv
// Capture sequencer for the SD command-line sampler: session FSM, record FIFO, byte drain, watchdog.
// Optional SDIO_CAP_TSTAMP_EN adds a 16-bit sd_clk timestamp to each record (7-byte records).
module sdio_cap_ctrl #(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         WDOG_CYCLES    = 512,
    parameter int         RECOVER_CYCLES = 2,
    parameter logic [7:0] SMP_IDLE       = 8'h01
) (
    input  logic        sd_clk,
    input  logic        rst,
    input  logic        arm_i,
    input  logic        stop_i,
    input  logic        trig_en_i,
    input  logic [5:0]  trig_idx_i,
    input  logic [7:0]  cap_limit_i,
    output logic        smp_en_o,
    input  logic [7:0]  smp_cmd_i,
    input  logic [32:0] smp_arg_i,
    input  logic        smp_finsh_i,
    input  logic [7:0]  smp_status_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_o,
    output logic [7:0]  rec_cnt_o,
    output logic [6:0]  fifo_level_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
`ifdef SDIO_CAP_TSTAMP_EN
    localparam int REC_W = 54;
    localparam int NB    = 7;
`else
    localparam int REC_W = 38;
    localparam int NB    = 5;
`endif

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic [2:0]       state_q, state_d, ret_q, ret_d;
    logic [RW-1:0]    rcv_q, rcv_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             fin_prev_q, fin_prev_d;
    logic             pend_q, pend_d;
    logic [REC_W-1:0] pend_rec_q, pend_rec_d;
    logic [7:0]       cap_lim_q, cap_lim_d;
    logic [7:0]       rec_cnt_q, rec_cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             valid_q, valid_d;
    logic [2:0]       idx_q, idx_d;
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];

    logic             ev, full, pop, push_ok, drop, flush;
    logic             wd_act, wd_fire, cap_hit;
    logic [AW:0]      level, level_d;
    logic [7:0]       rec_inc, byte_sel;
    logic [REC_W-1:0] rec_now, rd_rec;

`ifdef SDIO_CAP_TSTAMP_EN
    logic [15:0] ts_q, ts_d;
    assign ts_d    = ts_q + 16'd1;
    assign rec_now = {ts_q, smp_cmd_i[5:0], smp_arg_i[31:0]};
`else
    assign rec_now = {smp_cmd_i[5:0], smp_arg_i[31:0]};
`endif

    logic unused_bits;
    assign unused_bits = ^{smp_cmd_i[7:6], smp_arg_i[32]};

    assign smp_en_o = (state_q == S_ARMED) || (state_q == S_CAPT);
    assign ev       = smp_en_o && smp_finsh_i && !fin_prev_q;
    assign level    = wr_q - rd_q;
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign pop      = valid_q && byte_ready_i && (idx_q == 3'(NB - 1));
    // A full FIFO still accepts a push when the head record leaves on the same edge.
    assign push_ok  = pend_q && (!full || pop);
    assign drop     = pend_q && full && !pop;
    assign flush    = arm_i && (state_q != S_RECOVER);
    assign wd_act   = smp_en_o && (smp_status_i != SMP_IDLE)
                      && (smp_status_i != 8'h00);
    assign wd_fire  = wd_act && (wd_q == WW'(WDOG_CYCLES - 1));
    assign rec_inc  = (rec_cnt_q == 8'hff) ? rec_cnt_q : rec_cnt_q + 8'd1;
    assign cap_hit  = push_ok && (cap_lim_q != 8'd0) && (rec_inc == cap_lim_q);

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        rcv_d      = rcv_q;
        cap_lim_d  = cap_lim_q;
        fin_prev_d = smp_finsh_i;
        wd_d       = (wd_act && !wd_fire) ? wd_q + WW'(1) : '0;
        pend_d     = 1'b0;
        pend_rec_d = pend_rec_q;
        if (ev && ((state_q == S_CAPT) ||
                   ((state_q == S_ARMED) && (smp_cmd_i[5:0] == trig_idx_i)))) begin
            pend_d     = 1'b1;
            pend_rec_d = rec_now;
        end
        wr_d      = push_ok ? wr_q + (AW+1)'(1) : wr_q;
        rd_d      = pop ? rd_q + (AW+1)'(1) : rd_q;
        rec_cnt_d = push_ok ? rec_inc : rec_cnt_q;
        ovf_d     = ovf_q | drop;
        idx_d     = idx_q;
        if (valid_q && byte_ready_i)
            idx_d = (idx_q == 3'(NB - 1)) ? 3'd0 : idx_q + 3'd1;
        level_d = wr_d - rd_d;
        valid_d = (level != '0) && (level_d != '0);

        unique case (state_q)
            S_IDLE: ;
            S_ARMED: begin
                if (wd_fire) begin
                    state_d = S_RECOVER;
                    ret_d   = S_ARMED;
                    rcv_d   = '0;
                end else if (stop_i) begin
                    state_d = S_DONE;
                end else if (pend_d) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (wd_fire) begin
                    state_d = S_RECOVER;
                    ret_d   = S_CAPT;
                    rcv_d   = '0;
                end else if (stop_i || cap_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: ;
            S_RECOVER: begin
                if (rcv_q == RW'(RECOVER_CYCLES - 1))
                    state_d = ret_q;
                else
                    rcv_d = rcv_q + RW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d   = trig_en_i ? S_ARMED : S_CAPT;
            cap_lim_d = cap_limit_i;
            wd_d      = '0;
            pend_d    = 1'b0;
            wr_d      = '0;
            rd_d      = '0;
            rec_cnt_d = 8'd0;
            ovf_d     = 1'b0;
            valid_d   = 1'b0;
            idx_d     = 3'd0;
        end
    end

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            rcv_q      <= '0;
            wd_q       <= '0;
            fin_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_rec_q <= '0;
            cap_lim_q  <= 8'd0;
            rec_cnt_q  <= 8'd0;
            ovf_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            idx_q      <= 3'd0;
`ifdef SDIO_CAP_TSTAMP_EN
            ts_q       <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            rcv_q      <= rcv_d;
            wd_q       <= wd_d;
            fin_prev_q <= fin_prev_d;
            pend_q     <= pend_d;
            pend_rec_q <= pend_rec_d;
            cap_lim_q  <= cap_lim_d;
            rec_cnt_q  <= rec_cnt_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
`ifdef SDIO_CAP_TSTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    always_ff @(posedge sd_clk) begin
        if (push_ok && !flush)
            mem_q[wr_q[AW-1:0]] <= pend_rec_q;
    end

    assign rd_rec = mem_q[rd_q[AW-1:0]];

    always_comb begin
        byte_sel = 8'h00;
        unique case (idx_q)
            3'd0: byte_sel = {2'b00, rd_rec[37:32]};
            3'd1: byte_sel = rd_rec[31:24];
            3'd2: byte_sel = rd_rec[23:16];
            3'd3: byte_sel = rd_rec[15:8];
            3'd4: byte_sel = rd_rec[7:0];
`ifdef SDIO_CAP_TSTAMP_EN
            3'd5: byte_sel = rd_rec[53:46];
            3'd6: byte_sel = rd_rec[45:38];
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    assign byte_o       = valid_q ? byte_sel : 8'h00;
    assign byte_valid_o = valid_q;
    assign busy_o       = (state_q == S_ARMED) || (state_q == S_CAPT)
                          || (state_q == S_RECOVER);
    assign done_o       = (state_q == S_DONE);
    assign ovf_o        = ovf_q;
    assign rec_cnt_o    = rec_cnt_q;
    assign fifo_level_o = 7'(level);

endmodule

// File: tb/tb_sdio_cap_ctrl.sv
// Directed bench for sdio_cap_ctrl: vector table for record bytes plus hand-written corner sequences.
module tb_sdio_cap_ctrl;

    logic        sd_clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm_i = 1'b0, stop_i = 1'b0, trig_en_i = 1'b0;
    logic [5:0]  trig_idx_i = 6'd0;
    logic [7:0]  cap_limit_i = 8'd0;
    logic        smp_en_o;
    logic [7:0]  smp_cmd_i = 8'd0;
    logic [32:0] smp_arg_i = 33'd0;
    logic        smp_finsh_i = 1'b0;
    logic [7:0]  smp_status_i = 8'h01;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic        busy_o, done_o, ovf_o;
    logic [7:0]  rec_cnt_o;
    logic [6:0]  fifo_level_o;

    int checks = 0;
    int errors = 0;

    sdio_cap_ctrl dut (
        .sd_clk(sd_clk), .rst(rst),
        .arm_i(arm_i), .stop_i(stop_i),
        .trig_en_i(trig_en_i), .trig_idx_i(trig_idx_i),
        .cap_limit_i(cap_limit_i), .smp_en_o(smp_en_o),
        .smp_cmd_i(smp_cmd_i), .smp_arg_i(smp_arg_i),
        .smp_finsh_i(smp_finsh_i), .smp_status_i(smp_status_i),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i), .busy_o(busy_o),
        .done_o(done_o), .ovf_o(ovf_o),
        .rec_cnt_o(rec_cnt_o), .fifo_level_o(fifo_level_o)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] arg;
        logic [39:0] exp;
    } vec_t;

    vec_t vt[3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sd_clk);
        #1;
    endtask

    task automatic arm(input logic te, input logic [5:0] idx,
                       input logic [7:0] lim);
        trig_en_i   = te;
        trig_idx_i  = idx;
        cap_limit_i = lim;
        arm_i       = 1'b1;
        tick;
        arm_i       = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] cmd, input logic [31:0] arg);
        smp_cmd_i   = cmd;
        smp_arg_i   = {1'b0, arg};
        smp_finsh_i = 1'b1;
        tick;
        smp_finsh_i = 1'b0;
        tick;
    endtask

    task automatic get_rec(output logic [39:0] r, output logic ok);
        r  = '0;
        ok = 1'b1;
        byte_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int t = 0;
            while (!byte_valid_o && t < 100) begin
                tick;
                t++;
            end
            if (!byte_valid_o) begin
                ok = 1'b0;
                break;
            end
            r = {r[31:0], byte_o};
            tick;
        end
        byte_ready_i = 1'b0;
    endtask

    initial begin
        logic [39:0] r;
        logic        ok;
        int          n;
        int          unstable;

        vt[0] = '{8'd17, 32'h12345678, 40'h11_12345678};
        vt[1] = '{8'd18, 32'hDEADBEEF, 40'h12_DEADBEEF};
        vt[2] = '{8'd24, 32'h0BADF00D, 40'h18_0BADF00D};

        repeat (2) tick;
        chk("rst_smp_en", smp_en_o, 0);
        chk("rst_valid", byte_valid_o, 0);
        chk("rst_byte", byte_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_rec_cnt", rec_cnt_o, 0);
        chk("rst_level", fifo_level_o, 0);
        rst = 1'b1;
        tick;

        // untriggered capture with cap_limit 3
        arm(1'b0, 6'd0, 8'd3);
        chk("t1_smp_en", smp_en_o, 1);
        for (int i = 0; i < 3; i++) begin
            pulse(vt[i].cmd, vt[i].arg);
            get_rec(r, ok);
            chk($sformatf("t1_rec%0d_ok", i), ok, 1);
            chk($sformatf("t1_rec%0d", i), r, vt[i].exp);
        end
        chk("t1_done", done_o, 1);
        chk("t1_smp_en_off", smp_en_o, 0);
        chk("t1_rec_cnt", rec_cnt_o, 3);

        // trigger filtering
        arm(1'b1, 6'd9, 8'd0);
        chk("t2_busy", busy_o, 1);
        pulse(8'd2, 32'h22222222);
        chk("t2_drop_level", fifo_level_o, 0);
        pulse(8'd9, 32'h99990000);
        pulse(8'd3, 32'h33334444);
        chk("t2_rec_cnt", rec_cnt_o, 2);
        get_rec(r, ok);
        chk("t2_first", r, 40'h09_99990000);
        get_rec(r, ok);
        chk("t2_second", r, 40'h03_33334444);
        stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        chk("t2_stop_done", done_o, 1);

        // backpressure and overflow
        arm(1'b0, 6'd0, 8'd0);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            pulse(8'h20 + 8'(i), 32'(i));
            if (i >= 1 && !(byte_valid_o && byte_o == 8'h20))
                unstable++;
        end
        tick;
        chk("t3_level", fifo_level_o, 8);
        chk("t3_ovf", ovf_o, 1);
        chk("t3_rec_cnt", rec_cnt_o, 8);
        chk("t3_byte_stable", unstable, 0);
        get_rec(r, ok);
        chk("t3_head", r, 40'h20_00000000);
        byte_ready_i = 1'b1;
        n = 0;
        while (byte_valid_o && n < 200) begin
            n++;
            tick;
        end
        byte_ready_i = 1'b0;
        chk("t3_drain_bytes", n + 5, 40);
        chk("t3_empty", fifo_level_o, 0);

        // watchdog recovery
        arm(1'b0, 6'd0, 8'd0);
        smp_status_i = 8'h04;
        n = 0;
        while (smp_en_o && n < 1000) begin
            tick;
            n++;
        end
        smp_status_i = 8'h01;
        chk("t4_wdog_cycles", n, 512);
        chk("t4_recover_busy", busy_o, 1);
        tick;
        chk("t4_still_low", smp_en_o, 0);
        tick;
        chk("t4_resumed", smp_en_o, 1);
        chk("t4_no_rec", rec_cnt_o, 0);
        chk("t4_no_level", fifo_level_o, 0);

        // stalled finish flag, then stop with a finish event
        smp_cmd_i   = 8'd5;
        smp_arg_i   = 33'h55;
        smp_finsh_i = 1'b1;
        repeat (5) tick;
        smp_finsh_i = 1'b0;
        repeat (2) tick;
        chk("t5_one_rec", rec_cnt_o, 1);
        chk("t5_one_level", fifo_level_o, 1);
        smp_cmd_i   = 8'd6;
        smp_arg_i   = 33'h66;
        smp_finsh_i = 1'b1;
        stop_i      = 1'b1;
        tick;
        smp_finsh_i = 1'b0;
        stop_i      = 1'b0;
        tick;
        chk("t5_done", done_o, 1);
        chk("t5_stop_rec", rec_cnt_o, 2);
        chk("t5_stop_level", fifo_level_o, 2);

        // arm mid-stream
        chk("t6_valid_before", byte_valid_o, 1);
        byte_ready_i = 1'b1;
        tick;
        byte_ready_i = 1'b0;
        arm(1'b0, 6'd0, 8'd0);
        chk("t6_valid_drop", byte_valid_o, 0);
        chk("t6_level", fifo_level_o, 0);
        chk("t6_ovf", ovf_o, 0);
        chk("t6_rec_cnt", rec_cnt_o, 0);
        pulse(8'd7, 32'h01020304);
        get_rec(r, ok);
        chk("t6_idx_restart", r, 40'h07_01020304);

        // reset mid-stream
        pulse(8'd8, 32'h0);
        pulse(8'd9, 32'h0);
        tick;
        chk("t7_valid_pre", byte_valid_o, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t7_smp_en", smp_en_o, 0);
        chk("t7_valid", byte_valid_o, 0);
        chk("t7_byte", byte_o, 0);
        chk("t7_busy", busy_o, 0);
        chk("t7_level", fifo_level_o, 0);
        chk("t7_rec_cnt", rec_cnt_o, 0);
        tick;
        rst = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
